// File: rtl/compositor_pkg.sv
// Shared types and colour tables for the sprite layer compositor.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    BLACK    = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [23:0] DEFAULT_COLOR = 24'h010101;
  localparam int MAIN_ENTRIES  = 17;
  localparam int CYCLE_ENTRIES = 9;

  localparam logic [23:0] MAIN_PALETTE [MAIN_ENTRIES] = '{
    24'h010101, 24'h000000, 24'hF8F8F8, 24'hF0D0B0,
    24'hD03800, 24'hFFA044, 24'h3CBCFC, 24'h5888B8,
    24'h00A800, 24'hB8F818, 24'h7C7C7C, 24'hBCBCBC,
    24'h881400, 24'hE45C10, 24'h0000BC, 24'h6844FC,
    24'h00FF00
  };

  // Entry k holds cycle index k+1.
  localparam logic [23:0] CYCLE_PALETTE [CYCLE_ENTRIES] = '{
    24'hFFFFFF, 24'hD8B000, 24'hF8F000, 24'hE9C22D, 24'hF2EDB1,
    24'h1F97D6, 24'h6B91AF, 24'h05518B, 24'hE6E3E3
  };

endpackage

// File: rtl/compositor_palette.sv
// Combinational colour lookup for the winning index, main or cycle palette.
module compositor_palette
  import compositor_pkg::*;
#(
  parameter int INDEX_W = 5
) (
  input  logic [INDEX_W-1:0] index_i,
  input  logic               use_cycle_i,
  output logic [23:0]        color_o
);

  logic [31:0] idx32_s;
  logic [3:0]  cyc_pos_s;
  logic        main_hit_s;
  logic        cyc_hit_s;

  assign idx32_s    = 32'(index_i);
  assign main_hit_s = (idx32_s < 32'(MAIN_ENTRIES));
  assign cyc_hit_s  = (idx32_s >= 32'd1) && (idx32_s <= 32'(CYCLE_ENTRIES));
  assign cyc_pos_s  = idx32_s[3:0] - 4'd1;

  always_comb begin
    if (use_cycle_i) begin
      if (cyc_hit_s) color_o = CYCLE_PALETTE[cyc_pos_s];
      else           color_o = DEFAULT_COLOR;
    end else begin
      if (main_hit_s) color_o = MAIN_PALETTE[idx32_s[4:0]];
      else            color_o = DEFAULT_COLOR;
    end
  end

endmodule

// File: rtl/sprite_layer_compositor.sv
// Three-stage sprite compositor: priority select, palette lookup, fade and blank.
module sprite_layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS   = 8,
  parameter int INDEX_W      = 5,
  parameter int CYCLE_LEN    = 9,
  parameter int BLINK_PERIOD = 8,
  parameter int FADE_STEPS   = 8
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           frame_tick,
  input  logic                           VGA_BLANK_N,
  input  logic [NUM_LAYERS-1:0]          layer_valid,
  input  logic [NUM_LAYERS*INDEX_W-1:0]  layer_index,
  input  logic [23:0]                    bkg_color,
  input  logic [NUM_LAYERS-1:0]          cycle_mask,
  input  logic [NUM_LAYERS-1:0]          blink_mask,
  input  logic                           fade_start,
  input  logic                           fade_dir,
  output logic                           fade_done,
  output logic [$clog2(FADE_STEPS):0]    fade_level,
  output logic [7:0]                     VGA_R,
  output logic [7:0]                     VGA_G,
  output logic [7:0]                     VGA_B
);

  localparam int LOG2_STEPS = $clog2(FADE_STEPS);
  localparam int LVL_W      = LOG2_STEPS + 1;
  localparam int CNT_W      = (CYCLE_LEN > 1) ? $clog2(CYCLE_LEN) : 1;
  localparam int BLK_W      = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
  localparam int SUM_W      = 6;

  logic [CNT_W-1:0]      cyc_cnt_q, cyc_cnt_d;
  logic [BLK_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;

  fade_state_t           fade_state_q;
  logic [LVL_W-1:0]      fade_level_q;
  logic                  fade_done_q;

  logic [NUM_LAYERS-1:0] layer_opaque_s;
  logic [INDEX_W-1:0]    win_idx_s;
  logic                  win_cyc_s;
  logic                  in_range_s;
  logic [SUM_W-1:0]      sum_s;

  logic [INDEX_W-1:0]    s1_idx_q, s1_idx_d;
  logic                  s1_cyc_q, s1_cyc_d;
  logic                  s1_opaque_q, s1_opaque_d;
  logic [23:0]           s1_bkg_q;
  logic                  s1_blank_n_q;

  logic [23:0]           pal_color_s;
  logic [23:0]           s2_color_q, s2_color_d;
  logic                  s2_blank_n_q;

  logic [LVL_W-1:0]      scale_s;
  logic [23:0]           rgb_q, rgb_d;

  function automatic logic [7:0] attenuate(input logic [7:0] c, input logic [LVL_W-1:0] scale);
    logic [8+LVL_W-1:0] prod;
    prod = (8+LVL_W)'(c) * (8+LVL_W)'(scale);
    return prod[LOG2_STEPS +: 8];
  endfunction

  always_comb begin
    cyc_cnt_d     = cyc_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_tick) begin
      if (cyc_cnt_q == CNT_W'(CYCLE_LEN-1)) cyc_cnt_d = '0;
      else                                  cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
      if (blink_cnt_q == BLK_W'(BLINK_PERIOD-1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_q + BLK_W'(1);
      end
    end else begin
      cyc_cnt_d     = cyc_cnt_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cyc_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      cyc_cnt_q     <= cyc_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Priority select: the lowest-numbered opaque layer claims the pixel.
  always_comb begin
    layer_opaque_s = '0;
    s1_opaque_d    = 1'b0;
    win_idx_s      = '0;
    win_cyc_s      = 1'b0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      layer_opaque_s[l] = layer_valid[l] && (layer_index[l*INDEX_W +: INDEX_W] != '0)
                          && !(blink_mask[l] && !blink_phase_q);
    end
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (!s1_opaque_d && layer_opaque_s[l]) begin
        s1_opaque_d = 1'b1;
        win_idx_s   = layer_index[l*INDEX_W +: INDEX_W];
        win_cyc_s   = cycle_mask[l];
      end
    end
  end

  // Cycled index is resolved here so a pixel sees the count current at its S1 cycle.
  always_comb begin
    in_range_s = (win_idx_s != '0) && (32'(win_idx_s) <= 32'(CYCLE_LEN));
    s1_cyc_d   = s1_opaque_d && win_cyc_s && in_range_s;
    sum_s      = SUM_W'(win_idx_s) - SUM_W'(1) + SUM_W'(cyc_cnt_q);
    if (sum_s >= SUM_W'(CYCLE_LEN)) sum_s = sum_s - SUM_W'(CYCLE_LEN);
    else                            sum_s = sum_s;
    if (s1_cyc_d) s1_idx_d = INDEX_W'(sum_s + SUM_W'(1));
    else          s1_idx_d = win_idx_s;
  end

  compositor_palette #(.INDEX_W(INDEX_W)) u_palette (
    .index_i     (s1_idx_q),
    .use_cycle_i (s1_cyc_q),
    .color_o     (pal_color_s)
  );

  always_comb begin
    if (s1_opaque_q) s2_color_d = pal_color_s;
    else             s2_color_d = s1_bkg_q;
    scale_s = LVL_W'(FADE_STEPS) - fade_level_q;
    if (s2_blank_n_q) rgb_d = {attenuate(s2_color_q[23:16], scale_s),
                               attenuate(s2_color_q[15:8],  scale_s),
                               attenuate(s2_color_q[7:0],   scale_s)};
    else              rgb_d = 24'h000000;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_idx_q     <= '0;
      s1_cyc_q     <= 1'b0;
      s1_opaque_q  <= 1'b0;
      s1_bkg_q     <= 24'h000000;
      s1_blank_n_q <= 1'b0;
      s2_color_q   <= 24'h000000;
      s2_blank_n_q <= 1'b0;
      rgb_q        <= 24'h000000;
    end else begin
      s1_idx_q     <= s1_idx_d;
      s1_cyc_q     <= s1_cyc_d;
      s1_opaque_q  <= s1_opaque_d;
      s1_bkg_q     <= bkg_color;
      s1_blank_n_q <= VGA_BLANK_N;
      s2_color_q   <= s2_color_d;
      s2_blank_n_q <= s1_blank_n_q;
      rgb_q        <= rgb_d;
    end
  end

  // Fade sequencer; a start request that cannot move the state just acknowledges.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fade_state_q <= IDLE;
      fade_level_q <= '0;
      fade_done_q  <= 1'b0;
    end else begin
      fade_done_q <= 1'b0;
      case (fade_state_q)
        IDLE: begin
          if (fade_start) begin
            if (!fade_dir) fade_state_q <= FADE_OUT;
            else           fade_done_q  <= 1'b1;
          end
        end
        FADE_OUT: begin
          if (frame_tick) begin
            fade_level_q <= fade_level_q + LVL_W'(1);
            if (fade_level_q == LVL_W'(FADE_STEPS-1)) begin
              fade_state_q <= BLACK;
              fade_done_q  <= 1'b1;
            end
          end
        end
        BLACK: begin
          if (fade_start) begin
            if (fade_dir) fade_state_q <= FADE_IN;
            else          fade_done_q  <= 1'b1;
          end
        end
        FADE_IN: begin
          if (frame_tick) begin
            fade_level_q <= fade_level_q - LVL_W'(1);
            if (fade_level_q == LVL_W'(1)) begin
              fade_state_q <= IDLE;
              fade_done_q  <= 1'b1;
            end
          end
        end
        default: begin
          fade_state_q <= IDLE;
          fade_level_q <= '0;
        end
      endcase
    end
  end

  assign fade_done  = fade_done_q;
  assign fade_level = fade_level_q;
  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Directed and randomized bench for sprite_layer_compositor with a frame-level reference model.
module tb_sprite_layer_compositor;

  localparam int NL = 8;
  localparam int IW = 5;
  localparam int CL = 9;
  localparam int BP = 2;
  localparam int FS = 8;

  logic            Clk = 1'b0;
  logic            Reset, frame_tick, VGA_BLANK_N, fade_start, fade_dir;
  logic [NL-1:0]   layer_valid, cycle_mask, blink_mask;
  logic [NL*IW-1:0] layer_index;
  logic [23:0]     bkg_color;
  logic            fade_done;
  logic [3:0]      fade_level;
  logic [7:0]      VGA_R, VGA_G, VGA_B;

  int n_vec = 0;
  int n_err = 0;
  int tick_count = 0;
  int m_mode = 0;
  int m_level = 0;
  logic m_done = 1'b0;
  logic [24:0] pipe [$];

  logic [23:0] main_tab [17] = '{
    24'h010101, 24'h000000, 24'hF8F8F8, 24'hF0D0B0, 24'hD03800, 24'hFFA044,
    24'h3CBCFC, 24'h5888B8, 24'h00A800, 24'hB8F818, 24'h7C7C7C, 24'hBCBCBC,
    24'h881400, 24'hE45C10, 24'h0000BC, 24'h6844FC, 24'h00FF00};
  logic [23:0] cyc_tab [10] = '{
    24'h010101, 24'hFFFFFF, 24'hD8B000, 24'hF8F000, 24'hE9C22D, 24'hF2EDB1,
    24'h1F97D6, 24'h6B91AF, 24'h05518B, 24'hE6E3E3};
  logic [7:0] fade_tab [9] = '{8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};

  always #5 Clk = ~Clk;

  sprite_layer_compositor #(
    .NUM_LAYERS(NL), .INDEX_W(IW), .CYCLE_LEN(CL), .BLINK_PERIOD(BP), .FADE_STEPS(FS)
  ) dut (
    .Clk(Clk), .Reset(Reset), .frame_tick(frame_tick), .VGA_BLANK_N(VGA_BLANK_N),
    .layer_valid(layer_valid), .layer_index(layer_index), .bkg_color(bkg_color),
    .cycle_mask(cycle_mask), .blink_mask(blink_mask), .fade_start(fade_start),
    .fade_dir(fade_dir), .fade_done(fade_done), .fade_level(fade_level),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, VGA_R, VGA_G, VGA_B}, {8'h00, exp});
  endtask

  function automatic logic [23:0] main_lookup(input int idx);
    if (idx <= 16) return main_tab[idx];
    return 24'h010101;
  endfunction

  function automatic logic [23:0] cycle_lookup(input int k);
    if (k >= 1 && k <= 9) return cyc_tab[k];
    return 24'h010101;
  endfunction

  // Colour the pixel should have before fading, from the current frame count.
  function automatic logic [24:0] model_pixel();
    int cnt, idx;
    bit visible, found;
    logic [23:0] c;
    cnt = tick_count % CL;
    visible = ((tick_count / BP) % 2) == 0;
    c = bkg_color;
    found = 1'b0;
    for (int l = 0; l < NL; l++) begin
      idx = int'(layer_index[l*IW +: IW]);
      if (!found && layer_valid[l] && idx != 0 && (visible || !blink_mask[l])) begin
        found = 1'b1;
        if (cycle_mask[l] && idx <= CL) c = cycle_lookup(((idx - 1 + cnt) % CL) + 1);
        else c = main_lookup(idx);
      end
    end
    return {VGA_BLANK_N, c};
  endfunction

  function automatic logic [23:0] shade(input logic [24:0] p, input int lvl);
    int r, g, b;
    if (!p[24]) return 24'h000000;
    r = int'(p[23:16]) * (FS - lvl) / FS;
    g = int'(p[15:8])  * (FS - lvl) / FS;
    b = int'(p[7:0])   * (FS - lvl) / FS;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic step();
    logic [24:0] cur;
    int lvl_used;
    pipe.push_back(model_pixel());
    lvl_used = m_level;
    @(posedge Clk);
    m_done = 1'b0;
    if (Reset) begin
      tick_count = 0; m_mode = 0; m_level = 0;
      pipe.delete();
      pipe.push_back(25'd0);
      pipe.push_back(25'd0);
      cur = 25'd0;
    end else begin
      cur = pipe.pop_front();
      case (m_mode)
        0: if (fade_start) begin if (!fade_dir) m_mode = 1; else m_done = 1'b1; end
        1: if (frame_tick) begin
             m_level++;
             if (m_level == FS) begin m_mode = 2; m_done = 1'b1; end
           end
        2: if (fade_start) begin if (fade_dir) m_mode = 3; else m_done = 1'b1; end
        3: if (frame_tick) begin
             m_level--;
             if (m_level == 0) begin m_mode = 0; m_done = 1'b1; end
           end
        default: m_mode = 0;
      endcase
      if (frame_tick) tick_count++;
    end
    #1;
    check_rgb("rgb", shade(cur, lvl_used));
    check("fade_level", 32'(fade_level), 32'(m_level));
    check("fade_done", 32'(fade_done), 32'(m_done));
  endtask

  task automatic clear_inputs();
    Reset = 1'b0; frame_tick = 1'b0; VGA_BLANK_N = 1'b1; fade_start = 1'b0; fade_dir = 1'b0;
    layer_valid = '0; layer_index = '0; cycle_mask = '0; blink_mask = '0; bkg_color = 24'h000000;
  endtask

  task automatic set_layer(input int l, input logic v, input logic [IW-1:0] idx,
                           input logic cyc, input logic blk);
    layer_valid[l] = v;
    layer_index[l*IW +: IW] = idx;
    cycle_mask[l] = cyc;
    blink_mask[l] = blk;
  endtask

  task automatic do_reset();
    Reset = 1'b1; step(); Reset = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
  endtask

  task automatic settle();
    repeat (3) step();
  endtask

  initial begin
    pipe.push_back(25'd0);
    pipe.push_back(25'd0);
    clear_inputs();
    do_reset();
    check("reset_level", 32'(fade_level), 32'd0);
    check_rgb("reset_rgb", 24'h000000);

    // Priority between two opaque layers
    set_layer(2, 1'b1, 5'd4, 1'b0, 1'b0);
    set_layer(5, 1'b1, 5'd7, 1'b0, 1'b0);
    settle();
    check_rgb("prio_layer2", 24'hD03800);
    set_layer(2, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check_rgb("prio_layer5", 24'h5888B8);

    // Cycle palette wrap
    clear_inputs();
    do_reset();
    set_layer(0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check_rgb("cycle_0", 24'hE6E3E3);
    tick();
    settle();
    check_rgb("cycle_1", 24'hFFFFFF);
    repeat (8) tick();
    settle();
    check_rgb("cycle_9", 24'hE6E3E3);

    // Blink with a two-tick half-period
    clear_inputs();
    do_reset();
    bkg_color = 24'h123456;
    set_layer(0, 1'b1, 5'd2, 1'b0, 1'b1);
    for (int t = 0; t < 8; t++) begin
      settle();
      check_rgb("blink", (((t / 2) % 2) == 0) ? 24'hF8F8F8 : 24'h123456);
      tick();
    end

    // Fade out to black, then back in
    clear_inputs();
    do_reset();
    bkg_color = 24'hFFFFFF;
    fade_start = 1'b1; fade_dir = 1'b0;
    step();
    fade_start = 1'b0;
    for (int t = 0; t < 9; t++) begin
      settle();
      check("fade_out_r", 32'(VGA_R), 32'(fade_tab[t]));
      if (t < 8) begin
        tick();
        if (t == 7) check("fade_out_done", 32'(fade_done), 32'd1);
      end
    end
    check("fade_black_level", 32'(fade_level), 32'd8);
    fade_start = 1'b1; fade_dir = 1'b0;
    step();
    check("fade_out_in_black_done", 32'(fade_done), 32'd1);
    fade_dir = 1'b1;
    step();
    fade_start = 1'b0;
    repeat (8) tick();
    settle();
    check_rgb("fade_in_white", 24'hFFFFFF);
    check("fade_in_level", 32'(fade_level), 32'd0);

    // Blanking gates exactly one pixel
    clear_inputs();
    set_layer(0, 1'b1, 5'd4, 1'b0, 1'b0);
    settle();
    VGA_BLANK_N = 1'b0;
    step();
    VGA_BLANK_N = 1'b1;
    step();
    step();
    check_rgb("blank_gate", 24'h000000);
    step();
    check_rgb("blank_release", 24'hD03800);

    // Reset during a fade, coinciding with a frame tick
    clear_inputs();
    do_reset();
    set_layer(0, 1'b1, 5'd9, 1'b1, 1'b0);
    fade_start = 1'b1; fade_dir = 1'b0;
    step();
    fade_start = 1'b0;
    repeat (4) tick();
    check("midfade_level", 32'(fade_level), 32'd4);
    Reset = 1'b1; frame_tick = 1'b1;
    step();
    Reset = 1'b0; frame_tick = 1'b0;
    check("midfade_reset_level", 32'(fade_level), 32'd0);
    check_rgb("midfade_reset_rgb", 24'h000000);
    step();
    check_rgb("post_reset_1", 24'h000000);
    step();
    check_rgb("post_reset_2", 24'h000000);
    step();
    check_rgb("post_reset_3", 24'hE6E3E3);

    // Randomized traffic against the model
    clear_inputs();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      Reset       = ($urandom_range(0, 199) == 0);
      frame_tick  = ($urandom_range(0, 2) == 0);
      VGA_BLANK_N = ($urandom_range(0, 7) != 0);
      fade_start  = ($urandom_range(0, 15) == 0);
      fade_dir    = $urandom_range(0, 1) == 1;
      layer_valid = NL'($urandom);
      cycle_mask  = NL'($urandom);
      blink_mask  = NL'($urandom) & NL'($urandom);
      bkg_color   = 24'($urandom);
      for (int l = 0; l < NL; l++) layer_index[l*IW +: IW] = IW'($urandom_range(0, 31));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
